// File: rtl/banked_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : banked_mem_pkg
// Brief    : Shared constants and helpers for the four-bank main memory.
// Revision : 1.0
// ============================================================================
package banked_mem_pkg;

    localparam int NUM_BANKS        = 4;
    localparam int BANK_BUSY_CYCLES = 4;
    localparam int READ_LATENCY     = 2;
    localparam int BANK_SEL_LSB     = 1;
    localparam int BANK_SEL_W       = 2;
    localparam int DATA_W           = 16;
    localparam int ADDR_W           = 16;
    localparam int BUSY_CNT_W       = $clog2(BANK_BUSY_CYCLES);

    // Counter load value: the accepting cycle plus this many busy cycles.
    localparam logic [BUSY_CNT_W-1:0] BUSY_LOAD = BUSY_CNT_W'(BANK_BUSY_CYCLES - 1);

    function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
        return a[BANK_SEL_LSB +: BANK_SEL_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bank.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank
// Brief    : One memory bank: storage array, busy counter and row read.
// Revision : 1.0
// ============================================================================
module mem_bank
    import banked_mem_pkg::*;
#(
    parameter int DEPTH_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               acc_i,
    input  logic               wr_i,
    input  logic [DEPTH_W-1:0] row_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic               busy_o,
    output logic [DATA_W-1:0]  rdata_o
);

    logic [BUSY_CNT_W-1:0] cnt_q;
    logic [BUSY_CNT_W-1:0] cnt_d;
    logic [DATA_W-1:0]     mem_q [2**DEPTH_W];

    always_comb begin
        cnt_d = cnt_q;
        if (acc_i) begin
            cnt_d = BUSY_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (acc_i && wr_i) begin
            mem_q[row_i] <= wdata_i;
        end
    end

    assign busy_o  = (cnt_q != '0);
    assign rdata_o = mem_q[row_i];

endmodule
`default_nettype wire

// File: rtl/banked_mem.sv
`default_nettype none
// ============================================================================
// Module   : banked_mem
// Brief    : Four-bank word memory with per-bank busy window and 2-cycle reads.
// Revision : 1.0
// ============================================================================
module banked_mem
    import banked_mem_pkg::*;
#(
    parameter int DEPTH_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  rd_valid,
    output logic                  stall,
    output logic [NUM_BANKS-1:0]  busy,
    output logic                  err
);

    logic [BANK_SEL_W-1:0] w_bank;
    logic [DEPTH_W-1:0]    w_row;
    logic                  w_req;
    logic                  w_accept;
    logic [DATA_W-1:0]     w_bank_rdata [NUM_BANKS];
    logic                  w_unused;

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]     s1_data_q,  s1_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]     data_out_q, data_out_d;

    assign w_bank   = bank_of(addr);
    assign w_row    = addr[DEPTH_W+2:3];
    assign w_unused = ^addr[ADDR_W-1:DEPTH_W+3];

    // A double request or odd address is never a legal req, so it cannot stall.
    assign err      = (rd & wr) | ((rd | wr) & addr[0]);
    assign w_req    = (rd ^ wr) & ~addr[0];
    assign stall    = w_req & busy[w_bank];
    assign w_accept = w_req & ~busy[w_bank];

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            mem_bank #(
                .DEPTH_W (DEPTH_W)
            ) u_bank (
                .clk     (clk),
                .rst     (rst),
                .acc_i   (w_accept && (w_bank == BANK_SEL_W'(b))),
                .wr_i    (wr),
                .row_i   (w_row),
                .wdata_i (data_in),
                .busy_o  (busy[b]),
                .rdata_o (w_bank_rdata[b])
            );
        end
    endgenerate

    always_comb begin
        s1_valid_d = w_accept & rd;
        s1_data_d  = s1_data_q;
        if (w_accept && rd) begin
            s1_data_d = w_bank_rdata[w_bank];
        end
        rd_valid_d = s1_valid_q;
        data_out_d = data_out_q;
        if (s1_valid_q) begin
            data_out_d = s1_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            rd_valid_q <= rd_valid_d;
            data_out_q <= data_out_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_banked_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_mem
// Brief    : Directed self-checking bench for banked_mem with a read scoreboard.
// Revision : 1.0
// ============================================================================
module tb_banked_mem;

    logic        clk;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    banked_mem #(.DEPTH_W(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Read-return monitor: every rd_valid pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rd_unexpected", {31'd0, rd_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_cycle", cyc, e.cyc);
                check("rd_data", {16'd0, data_out}, {16'd0, e.data});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request for a single cycle; reads that should be accepted enqueue d.
    task automatic issue(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic es, input logic ee, input string tag);
        rd = r; wr = w; addr = a; data_in = d;
        #1;
        check({tag, "_stall"}, {31'd0, stall}, {31'd0, es});
        check({tag, "_err"},   {31'd0, err},   {31'd0, ee});
        if (r && !w && !es && !ee) sb.push_back('{d, cyc + 2});
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    // Called in the cycle after an accept: busy for three cycles, clear on the fourth.
    task automatic busy_window(input int b, input string tag);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("%s_busy%0d_c%0d", tag, b, i), {31'd0, busy[b]}, {31'd0, (i < 4)});
            if (i < 4) idle(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_out", {16'd0, data_out}, 32'h0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'h0);
        check("rst_busy",     {28'd0, busy},     32'h0);
        rd = 1'b1; addr = 16'h0010;
        #1;
        check("rst_rd_stall", {31'd0, stall}, 32'h0);
        check("rst_rd_err",   {31'd0, err},   32'h0);
        wr = 1'b1;
        #1;
        check("rst_rdwr_err",   {31'd0, err},   32'h1);
        check("rst_rdwr_stall", {31'd0, stall}, 32'h0);
        rd = 1'b0; wr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        // Single write/read to bank 0 with busy windows
        issue(0, 1, 16'h0010, 16'hBEEF, 0, 0, "t1_wr");
        busy_window(0, "t1_wr");
        issue(1, 0, 16'h0010, 16'hBEEF, 0, 0, "t1_rd");
        busy_window(0, "t1_rd");

        // Same-bank stall window on bank 1
        issue(0, 1, 16'h0002, 16'h1111, 0, 0, "t2_wr0");
        issue(0, 1, 16'h0002, 16'h2222, 1, 0, "t2_st1");
        issue(0, 1, 16'h0002, 16'h2222, 1, 0, "t2_st2");
        issue(0, 1, 16'h0002, 16'h2222, 1, 0, "t2_st3");
        issue(0, 1, 16'h0002, 16'h2222, 0, 0, "t2_wr4");
        idle(3);
        issue(1, 0, 16'h0002, 16'h2222, 0, 0, "t2_rd");
        idle(3);

        // All four banks in flight, back-to-back reads
        for (int i = 0; i < 4; i++)
            issue(0, 1, 16'h0100 + 16'(2 * i), 16'hA000 + 16'(i), 0, 0, $sformatf("t3_wr%0d", i));
        for (int i = 0; i < 4; i++)
            issue(1, 0, 16'h0100 + 16'(2 * i), 16'hA000 + 16'(i), 0, 0, $sformatf("t3_rd%0d", i));
        idle(4);
        check("t3_hold", {16'd0, data_out}, 32'h0000A003);
        check("t3_busy_idle", {28'd0, busy}, 32'h0);

        // Illegal requests: no state change, err wins over stall
        issue(1, 1, 16'h0010, 16'h0000, 0, 1, "t4_rdwr");
        check("t4_rdwr_busy", {28'd0, busy}, 32'h0);
        issue(1, 0, 16'h0011, 16'h0000, 0, 1, "t4_odd");
        check("t4_odd_busy", {28'd0, busy}, 32'h0);
        issue(0, 1, 16'h0004, 16'h3333, 0, 0, "t4_wrb2");
        issue(1, 1, 16'h0004, 16'h0000, 0, 1, "t4_rdwr_busy");
        issue(1, 0, 16'h0005, 16'h0000, 0, 1, "t4_odd_busy");
        check("t4_b2_count", {28'd0, busy}, 32'h4);
        idle(1);
        check("t4_b2_clear", {28'd0, busy}, 32'h0);
        idle(2);

        // Reset while a read is in flight: nothing returns, storage kept
        rd = 1'b1; addr = 16'h0010;
        #1;
        check("t5_rd_stall", {31'd0, stall}, 32'h0);
        @(posedge clk);
        #1;
        rd = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("t5_busy_rst",  {28'd0, busy},     32'h0);
        check("t5_rdv_rst",   {31'd0, rd_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("t5_rdv_after", {31'd0, rd_valid}, 32'h0);
        check("t5_dout_rst",  {16'd0, data_out}, 32'h0);
        rst = 1'b1;
        idle(3);
        issue(1, 0, 16'h0010, 16'hBEEF, 0, 0, "t5_rd0");
        issue(1, 0, 16'h0002, 16'h2222, 0, 0, "t5_rd1");
        idle(4);

        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
